// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit memory initiator.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_HALF = 1'b1;

  localparam int MEM_BYTES_DEF = 128;

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational byte-lane logic: load lane extract/extend and store lane merge
// into a captured halfword (little-endian: lane 0 = bits [7:0]).
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic        lane,
  input  logic        sgn,
  input  logic        size,
  input  logic [15:0] rdata,
  input  logic [7:0]  wbyte,
  input  logic [15:0] old_half,
  output logic [15:0] load_data,
  output logic [15:0] merge_data
);

  logic [7:0] sel_byte;

  always_comb begin
    sel_byte = lane ? rdata[15:8] : rdata[7:0];
    if (size == SIZE_HALF) begin
      load_data = rdata;
    end else begin
      load_data = {{8{sgn & sel_byte[7]}}, sel_byte};
    end
    merge_data = lane ? {wbyte, old_half[7:0]} : {old_half[15:8], wbyte};
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// LSU initiator side of the data-memory port; byte stores use read-modify-write.
// Optional: define LSU_ALIGN_CHECK_EN to reject odd-address halfword requests.
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MEM_BYTES = MEM_BYTES_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic              req_size_i,
  input  logic              req_signed_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              resp_valid_o,
  output logic [DATA_W-1:0] resp_rdata_o,
  output logic              resp_err_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  input  logic [DATA_W-1:0] mem_data_i
);

  // One extra bit so addr+1 at the top of the address space cannot wrap.
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_BYTES);

  lsu_state_e state, state_nxt;

  logic              we_q, size_q, sgn_q, err_q;
  logic [ADDR_W-1:0] addr_q, eff_addr;
  logic [DATA_W-1:0] wdata_q, old_q, rdata_q;
  logic [DATA_W-1:0] load_data, merge_data;
  logic              accept, req_err;
  logic [ADDR_W:0]   addr_ext, last_byte;

  assign accept    = req_valid_i && (state == IDLE);
  assign addr_ext  = {1'b0, req_addr_i};
  assign last_byte = (req_size_i == SIZE_HALF) ? addr_ext + (ADDR_W+1)'(1) : addr_ext;

  always_comb begin
    req_err = (last_byte >= LIMIT);
`ifdef LSU_ALIGN_CHECK_EN
    if ((req_size_i == SIZE_HALF) && req_addr_i[0]) req_err = 1'b1;
`endif
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)                      state_nxt = DONE;
          else if (!req_we_i)               state_nxt = RD;
          else if (req_size_i == SIZE_HALF) state_nxt = WR;
          else                              state_nxt = RD;
        end
      end
      RD:      state_nxt = we_q ? WR : DONE;
      WR:      state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  assign eff_addr = (size_q == SIZE_HALF) ? addr_q : {addr_q[ADDR_W-1:1], 1'b0};

  lsu_byte_lane u_lane (
    .lane       (addr_q[0]),
    .sgn        (sgn_q),
    .size       (size_q),
    .rdata      (mem_data_i),
    .wbyte      (wdata_q[7:0]),
    .old_half   (old_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_comb begin
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    mem_addr_o  = '0;
    mem_data_o  = '0;
    case (state)
      RD: begin
        mem_read_o = 1'b1;
        mem_addr_o = eff_addr;
      end
      WR: begin
        mem_write_o = 1'b1;
        mem_addr_o  = eff_addr;
        mem_data_o  = (size_q == SIZE_HALF) ? wdata_q : merge_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      we_q    <= 1'b0;
      size_q  <= SIZE_BYTE;
      sgn_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      old_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        we_q    <= req_we_i;
        size_q  <= req_size_i;
        sgn_q   <= req_signed_i;
        err_q   <= req_err;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
      end
      if (state == RD) begin
        if (we_q) old_q   <= mem_data_i;
        else      rdata_q <= load_data;
      end
    end
  end

  assign req_ready_o  = (state == IDLE);
  assign resp_valid_o = (state == DONE);
  assign resp_err_o   = (state == DONE) && err_q;
  assign resp_rdata_o = rdata_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Self-checking bench: byte-array memory behind the port, plus a reference byte
// array updated from the architectural load/store rules.
module tb_lsu_mem_initiator;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i, req_we_i, req_size_i, req_signed_i;
  logic [15:0] req_addr_i, req_wdata_i;
  logic        req_ready_o, resp_valid_o, resp_err_o;
  logic [15:0] resp_rdata_o, mem_addr_o, mem_data_o, mem_data_i;
  logic        mem_read_o, mem_write_o;

  logic [7:0]  mem     [0:127];
  logic [7:0]  ref_mem [0:127];
  logic        mem_init;
  logic [15:0] exp_rdata;
  int          vectors;
  int          miscompares;

  always #5 clk_i = ~clk_i;

  lsu_mem_initiator dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_size_i   (req_size_i),
    .req_signed_i (req_signed_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .resp_valid_o (resp_valid_o),
    .resp_rdata_o (resp_rdata_o),
    .resp_err_o   (resp_err_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_read_o   (mem_read_o),
    .mem_write_o  (mem_write_o),
    .mem_data_i   (mem_data_i)
  );

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 37 + 5) & 255);
  endfunction

  always_comb begin
    mem_data_i = 16'h0000;
    if (mem_addr_o < 16'd128) mem_data_i[7:0]  = mem[mem_addr_o[6:0]];
    if (mem_addr_o < 16'd127) mem_data_i[15:8] = mem[mem_addr_o[6:0] + 7'd1];
  end

  always @(posedge clk_i) begin
    if (mem_init) begin
      for (int i = 0; i < 128; i++) mem[i] <= init_byte(i);
    end else if (mem_write_o) begin
      if (mem_addr_o < 16'd128) mem[mem_addr_o[6:0]] <= mem_data_o[7:0];
      if (mem_addr_o < 16'd127) mem[mem_addr_o[6:0] + 7'd1] <= mem_data_o[15:8];
    end
  end

  task automatic do_req(input logic we, input logic size, input logic sgn,
                        input logic [15:0] addr, input logic [15:0] wdata);
    logic        err, got, obs_err;
    int          a, base, exp_lat, exp_rd, exp_wr, lat, rd_cnt, wr_cnt;
    logic [15:0] exp_addr, exp_wd, obs_raddr, obs_waddr, obs_wd;
    logic [7:0]  b;
    a        = int'(addr);
    err      = size ? (a + 1 >= 128) : (a >= 128);
`ifdef LSU_ALIGN_CHECK_EN
    if (size && addr[0]) err = 1'b1;
`endif
    exp_addr = size ? addr : {addr[15:1], 1'b0};
    base     = int'(exp_addr);
    exp_wd   = 16'h0000;
    if (err) begin
      exp_lat = 1; exp_rd = 0; exp_wr = 0;
    end else if (!we) begin
      exp_lat = 2; exp_rd = 1; exp_wr = 0;
      if (size) exp_rdata = {ref_mem[a + 1], ref_mem[a]};
      else begin
        b = ref_mem[a];
        exp_rdata = {{8{sgn & b[7]}}, b};
      end
    end else if (size) begin
      exp_lat = 2; exp_rd = 0; exp_wr = 1;
      exp_wd = wdata;
      ref_mem[a] = wdata[7:0];
      ref_mem[a + 1] = wdata[15:8];
    end else begin
      exp_lat = 3; exp_rd = 1; exp_wr = 1;
      exp_wd = addr[0] ? {wdata[7:0], ref_mem[base]} : {ref_mem[base + 1], wdata[7:0]};
      ref_mem[a] = wdata[7:0];
    end

    @(negedge clk_i);
    vectors++;
    if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL idle: ready=%b resp_valid=%b, want 1/0", req_ready_o, resp_valid_o);
    end
    req_valid_i = 1'b1; req_we_i = we; req_size_i = size;
    req_signed_i = sgn; req_addr_i = addr; req_wdata_i = wdata;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    req_addr_i  = 16'($urandom);
    req_wdata_i = 16'($urandom);
    req_we_i    = 1'($urandom);
    req_size_i  = 1'($urandom);

    got = 1'b0; obs_err = 1'b0; lat = 0; rd_cnt = 0; wr_cnt = 0;
    obs_raddr = 16'h0; obs_waddr = 16'h0; obs_wd = 16'h0;
    for (int n = 1; n <= 8 && !got; n++) begin
      @(negedge clk_i);
      if (mem_read_o)  begin rd_cnt++; obs_raddr = mem_addr_o; end
      if (mem_write_o) begin wr_cnt++; obs_waddr = mem_addr_o; obs_wd = mem_data_o; end
      if (mem_read_o && mem_write_o) begin
        vectors++; miscompares++;
        $display("FAIL strobes: read and write both 1 at addr %h", addr);
      end
      if (resp_valid_o) begin got = 1'b1; lat = n; obs_err = resp_err_o; end
    end

    vectors++;
    if (!got || lat != exp_lat) begin
      miscompares++;
      $display("FAIL latency addr=%h we=%b sz=%b: got %0d (seen=%b), want %0d",
               addr, we, size, lat, got, exp_lat);
    end
    vectors++;
    if (obs_err !== err) begin
      miscompares++;
      $display("FAIL err addr=%h sz=%b: got %b, want %b", addr, size, obs_err, err);
    end
    vectors++;
    if (rd_cnt != exp_rd || wr_cnt != exp_wr) begin
      miscompares++;
      $display("FAIL strobe count addr=%h: rd=%0d wr=%0d, want %0d/%0d",
               addr, rd_cnt, wr_cnt, exp_rd, exp_wr);
    end
    if (exp_rd > 0) begin
      vectors++;
      if (obs_raddr !== exp_addr) begin
        miscompares++;
        $display("FAIL read addr: got %h, want %h", obs_raddr, exp_addr);
      end
    end
    if (exp_wr > 0) begin
      vectors++;
      if (obs_waddr !== exp_addr || obs_wd !== exp_wd) begin
        miscompares++;
        $display("FAIL write: addr %h data %h, want %h %h", obs_waddr, obs_wd, exp_addr, exp_wd);
      end
      vectors++;
      if (mem[a] !== ref_mem[a]) begin
        miscompares++;
        $display("FAIL mem byte %h: got %h, want %h", addr, mem[a], ref_mem[a]);
      end
    end
    vectors++;
    if (resp_rdata_o !== exp_rdata) begin
      miscompares++;
      $display("FAIL rdata addr=%h we=%b sz=%b sg=%b: got %h, want %h",
               addr, we, size, sgn, resp_rdata_o, exp_rdata);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b0; mem_init = 1'b1;
    req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 1'b0; req_signed_i = 1'b0;
    req_addr_i = 16'h0; req_wdata_i = 16'h0;
    for (int i = 0; i < 128; i++) ref_mem[i] = init_byte(i);
    exp_rdata = 16'h0000;
    repeat (2) @(posedge clk_i);
    #1;
    vectors++;
    if ({req_ready_o, resp_valid_o, resp_err_o, mem_read_o, mem_write_o} !== 5'b10000 ||
        resp_rdata_o !== 16'h0 || mem_addr_o !== 16'h0 || mem_data_o !== 16'h0) begin
      miscompares++;
      $display("FAIL reset: rdy=%b rv=%b err=%b rd=%b wr=%b rdata=%h addr=%h data=%h",
               req_ready_o, resp_valid_o, resp_err_o, mem_read_o, mem_write_o,
               resp_rdata_o, mem_addr_o, mem_data_o);
    end
    @(negedge clk_i);
    mem_init = 1'b0;
    rst_i = 1'b1;
  endtask

  task automatic test_directed();
    do_req(1'b1, 1'b1, 1'b0, 16'h0004, 16'hBEEF);
    do_req(1'b0, 1'b0, 1'b1, 16'h0005, 16'h0000);
    do_req(1'b0, 1'b0, 1'b0, 16'h0005, 16'h0000);
    do_req(1'b1, 1'b0, 1'b0, 16'h0004, 16'h0012);
    do_req(1'b0, 1'b1, 1'b0, 16'h0004, 16'h0000);
    do_req(1'b0, 1'b0, 1'b1, 16'h007F, 16'h0000);
    do_req(1'b0, 1'b1, 1'b0, 16'h0080, 16'h0000);
    do_req(1'b0, 1'b1, 1'b0, 16'h007E, 16'h0000);
    do_req(1'b0, 1'b1, 1'b0, 16'h007F, 16'h0000);
    do_req(1'b1, 1'b0, 1'b0, 16'h0080, 16'h00AA);
    do_req(1'b0, 1'b1, 1'b0, 16'h0003, 16'h0000);
    do_req(1'b1, 1'b1, 1'b0, 16'h0009, 16'hC3A5);
    do_req(1'b1, 1'b0, 1'b0, 16'h007F, 16'h005A);
    do_req(1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0000);
  endtask

  task automatic test_reset_mid_write();
    logic seen;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 1'b0;
    req_signed_i = 1'b0; req_addr_i = 16'h0006; req_wdata_i = 16'h0055;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 5 && !seen; n++) begin
      @(negedge clk_i);
      if (mem_write_o) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL rst_wr: no write cycle seen, got 0 want 1");
    end
    rst_i = 1'b0;
    #1;
    vectors++;
    if (mem_write_o !== 1'b0 || req_ready_o !== 1'b1 || resp_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_wr outputs: wr=%b rdy=%b rv=%b, want 0/1/0",
               mem_write_o, req_ready_o, resp_valid_o);
    end
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    exp_rdata = 16'h0000;
    vectors++;
    if (mem[6] !== ref_mem[6] || mem[7] !== ref_mem[7]) begin
      miscompares++;
      $display("FAIL rst_wr mem: got %h%h, want %h%h", mem[7], mem[6], ref_mem[7], ref_mem[6]);
    end
    for (int n = 0; n < 3; n++) begin
      @(negedge clk_i);
      vectors++;
      if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
        miscompares++;
        $display("FAIL rst_wr resp: rv=%b rdy=%b, want 0/1", resp_valid_o, req_ready_o);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] addr;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) addr = 16'($urandom_range(120, 135));
      else                            addr = 16'($urandom_range(0, 127));
      do_req(1'($urandom), 1'($urandom), 1'($urandom), addr, 16'($urandom));
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_directed();
    test_reset_mid_write();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
